// File: rtl/dm_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
package dm_pkg;
   localparam int DM_ADDR_W     = 16;
   localparam int DM_DATA_W     = 16;
   localparam int DM_DEPTH_LOG2 = 12;
   localparam int DM_LATENCY    = 4;
   localparam int CNT_W         = 4;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/dm_array.sv
// Single-port synchronous word array, no reset; rdata registered, write-first.
// Latency 1 cycle; no backpressure (accepts every cycle).
// A write returns the written word on rdata so read-with-write sees new data.
module dm_array #(
   parameter int DEPTH_LOG2 = 12,
   parameter int DATA_W     = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);
   logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata     <= mem[addr];
      end
   end
endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder with fixed LATENCY; optional DM_ACCESS_STATS_EN adds rd_cnt/wr_cnt.
// Latency: request cycle 0 -> DONE in cycle LATENCY; one access per LATENCY+1 cycles.
// Backpressure: combinational stall while a request waits in IDLE and throughout WAIT.
module data_mem_responder
   import dm_pkg::*;
#(
   parameter int ADDR_W     = DM_ADDR_W,
   parameter int DATA_W     = DM_DATA_W,
   parameter int DEPTH_LOG2 = DM_DEPTH_LOG2,
   parameter int LATENCY    = DM_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              re,
   input  logic              we,
   input  logic [DATA_W-1:0] wrt_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              stall,
   output logic              busy
`ifdef DM_ACCESS_STATS_EN
   ,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt
`endif
);
   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   op_t                     cap_op, op_now;
   logic [DEPTH_LOG2-1:0]   cap_addr, arr_addr;
   logic [DATA_W-1:0]       cap_wdata, arr_wdata, arr_rdata, rd_data_q;
   logic                    req, enter_done, arr_we;
   logic                    unused_addr_hi;

   assign req            = re | we;
   assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2];

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      enter_done = 1'b0;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            stall = req;
            if (req) begin
               cnt_nxt = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_nxt  = DONE;
                  enter_done = 1'b1;
               end else begin
                  state_nxt  = WAIT;
               end
            end
         end
         WAIT: begin
            stall   = 1'b1;
            cnt_nxt = cnt - 1'b1;
            if (cnt <= CNT_W'(1)) begin
               state_nxt  = DONE;
               enter_done = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (rst) stall = 1'b0;
   end

   // In IDLE the array sees the live request so LATENCY=1 completes at the capture edge.
   assign op_now    = (state == IDLE) ? (we ? OP_WR : OP_RD) : cap_op;
   assign arr_addr  = (state == IDLE) ? addr[DEPTH_LOG2-1:0] : cap_addr;
   assign arr_wdata = (state == IDLE) ? wrt_data : cap_wdata;
   assign arr_we    = enter_done & (op_now == OP_WR) & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_data_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == DONE) rd_data_q <= arr_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_op <= OP_RD;
      end else if (state == IDLE && req) begin
         cap_op    <= op_now;
         cap_addr  <= addr[DEPTH_LOG2-1:0];
         cap_wdata <= wrt_data;
      end
   end

   dm_array #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_array (
      .clk   (clk),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   assign rd_data = (state == DONE) ? arr_rdata : rd_data_q;
   assign busy    = (state != IDLE);

`ifdef DM_ACCESS_STATS_EN
   logic [15:0] rd_cnt_q, wr_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (state == DONE) begin
         if (cap_op == OP_WR && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
         if (cap_op == OP_RD && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
   end

   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=4 and LATENCY=1 instances, scoreboard on DONE cycles.
module tb_data_mem_responder;
   import dm_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr, wdata;
   logic        re4, we4, re1, we1;
   logic [15:0] rd4, rd1;
   logic        stall4, busy4, stall1, busy1;
`ifdef DM_ACCESS_STATS_EN
   logic [15:0] rc4, wc4, rc1, wc1;
`endif

   always #5 clk = ~clk;

   data_mem_responder #(.LATENCY(4)) u4 (
      .clk(clk), .rst(rst), .addr(addr), .re(re4), .we(we4), .wrt_data(wdata),
      .rd_data(rd4), .stall(stall4), .busy(busy4)
`ifdef DM_ACCESS_STATS_EN
      , .rd_cnt(rc4), .wr_cnt(wc4)
`endif
   );

   data_mem_responder #(.LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .addr(addr), .re(re1), .we(we1), .wrt_data(wdata),
      .rd_data(rd1), .stall(stall1), .busy(busy1)
`ifdef DM_ACCESS_STATS_EN
      , .rd_cnt(rc1), .wr_cnt(wc1)
`endif
   );

   int tests = 0;
   int fails = 0;
   int n_rd  = 0;
   int n_wr  = 0;

   typedef struct {
      logic        chk;
      logic [15:0] exp;
   } sb_t;
   sb_t q4[$];
   sb_t q1[$];
   sb_t e4, e1;

   typedef struct {
      logic        r;
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic        chk;
      logic [15:0] exp;
   } vec_t;
   vec_t tv[12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard pop on every DONE cycle (busy without stall)
   always @(negedge clk) begin
      if (rst === 1'b0 && busy4 === 1'b1 && stall4 === 1'b0) begin
         if (q4.size() == 0) check("u4_unexpected_done", 32'd1, 32'd0);
         else begin
            e4 = q4.pop_front();
            if (e4.chk) check("u4_rd_data", {16'h0, rd4}, {16'h0, e4.exp});
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b0 && busy1 === 1'b1 && stall1 === 1'b0) begin
         if (q1.size() == 0) check("u1_unexpected_done", 32'd1, 32'd0);
         else begin
            e1 = q1.pop_front();
            if (e1.chk) check("u1_rd_data", {16'h0, rd1}, {16'h0, e1.exp});
         end
      end
   end

   // One access held per the stall protocol; consecutive calls are back-to-back.
   task automatic acc(input bit sel, input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic chk, input logic [15:0] exp,
                      input bit scr);
      int  lat;
      sb_t e;
      lat = sel ? 1 : 4;
      @(posedge clk); #1;
      addr  = a;
      wdata = d;
      if (sel) begin re1 = r; we1 = w; end
      else     begin re4 = r; we4 = w; end
      e.chk = chk;
      e.exp = exp;
      if (sel) q1.push_back(e); else q4.push_back(e);
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         check(c < lat ? "stall_busy_phase" : "stall_done_cycle",
               {31'b0, (sel ? stall1 : stall4)}, (c < lat) ? 32'd1 : 32'd0);
         if (c == lat) check("busy_done_cycle", {31'b0, (sel ? busy1 : busy4)}, 32'd1);
         if (scr && c == 0) begin
            @(posedge clk); #1;
            addr  = ~a;
            wdata = ~d;
         end
      end
      if (!sel) begin
         if (w) n_wr++;
         else if (r) n_rd++;
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      re4 = 1'b0; we4 = 1'b0; re1 = 1'b0; we1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
      tv[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF};
      tv[2]  = '{1'b0, 1'b1, 16'h1005, 16'h1234, 1'b0, 16'h0000};
      tv[3]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234};
      tv[4]  = '{1'b1, 1'b1, 16'h0020, 16'h00A5, 1'b1, 16'h00A5};
      tv[5]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h00A5};
      tv[6]  = '{1'b0, 1'b1, 16'h0030, 16'h0000, 1'b0, 16'h0000};
      tv[7]  = '{1'b0, 1'b1, 16'h0011, 16'hCAFE, 1'b0, 16'h0000};
      tv[8]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'hCAFE};
      tv[9]  = '{1'b1, 1'b0, 16'hF030, 16'h0000, 1'b1, 16'h0000};
      tv[10] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234};
      tv[11] = '{1'b1, 1'b0, 16'h1010, 16'h0000, 1'b1, 16'hBEEF};

      rst = 1'b1; addr = '0; wdata = '0;
      re4 = 1'b0; we4 = 1'b0; re1 = 1'b0; we1 = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      check("rst_rd4",    {16'h0, rd4},    32'd0);
      check("rst_stall4", {31'b0, stall4}, 32'd0);
      check("rst_busy4",  {31'b0, busy4},  32'd0);
      check("rst_rd1",    {16'h0, rd1},    32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_stall4", {31'b0, stall4}, 32'd0);
      check("idle_rd4",    {16'h0, rd4},    32'd0);

      for (int i = 0; i < 12; i++)
         acc(1'b0, tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].chk, tv[i].exp, 1'b0);
      idle();

      // rd_data holds its last completion while idle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_rd4",    {16'h0, rd4},    32'h0000BEEF);
         check("hold_stall4", {31'b0, stall4}, 32'd0);
         check("hold_busy4",  {31'b0, busy4},  32'd0);
      end

      // Inputs changing during WAIT are ignored
      acc(1'b0, 1'b0, 1'b1, 16'h0040, 16'h1111, 1'b0, 16'h0000, 1'b1);
      acc(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'h1111, 1'b0);
      acc(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b1);
      idle();

      // Reset during WAIT aborts the write
      @(posedge clk); #1;
      addr = 16'h0030; wdata = 16'h5555; we4 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort_stall_in_rst", {31'b0, stall4}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; we4 = 1'b0;
      @(negedge clk);
      check("abort_busy",  {31'b0, busy4},  32'd0);
      check("abort_stall", {31'b0, stall4}, 32'd0);
      check("abort_rd",    {16'h0, rd4},    32'd0);
      acc(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h0000, 1'b0);
      idle();

      // LATENCY=1: back-to-back accesses, stall pattern 1,0,1,0
      acc(1'b1, 1'b0, 1'b1, 16'h0001, 16'hA001, 1'b0, 16'h0000, 1'b0);
      acc(1'b1, 1'b0, 1'b1, 16'h0002, 16'hA002, 1'b0, 16'h0000, 1'b0);
      idle();
      acc(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'hA001, 1'b0);
      acc(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'hA002, 1'b0);
      acc(1'b1, 1'b1, 1'b1, 16'h0003, 16'h5A5A, 1'b1, 16'h5A5A, 1'b0);
      acc(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'hA001, 1'b0);
      idle();
      @(negedge clk);
      check("u1_idle_rd", {16'h0, rd1}, 32'h0000A001);

`ifdef DM_ACCESS_STATS_EN
      @(negedge clk);
      check("rd_cnt", {16'h0, rc4}, n_rd);
      check("wr_cnt", {16'h0, wc4}, n_wr);
      force u4.wr_cnt_q = 16'hFFFF;
      @(posedge clk); #1;
      release u4.wr_cnt_q;
      acc(1'b0, 1'b0, 1'b1, 16'h0050, 16'h7777, 1'b0, 16'h0000, 1'b0);
      idle();
      @(negedge clk);
      check("wr_cnt_sat", {16'h0, wc4}, 32'h0000FFFF);
      check("rd_cnt_after_sat", {16'h0, rc4}, n_rd);
`endif

      repeat (2) @(negedge clk);
      check("q4_drained", q4.size(), 32'd0);
      check("q1_drained", q1.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface: accepts the CPU's `re`/`we`/`addr`/`wrt_data` requests and returns `rd_data`.
- Models a multi-cycle backing store with a fixed access latency and raises `stall` so the pipelined CPU freezes until the access completes.
- Replaces the single-cycle data memory in the pipelined core.
- Sits between the MEM stage and the word-addressed storage array.

Parameters:
- ADDR_W, 16, CPU address width (word addresses).
- DATA_W, 16, data word width.
- DEPTH_LOG2, 12, log2 of storage depth in words (4096).
- LATENCY, 4, cycles from request accept to completion; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  word address; held stable by CPU while `stall`=1.
- re  in  1  read request.
- we  in  1  write request.
- wrt_data  in  DATA_W  write data; held stable while `stall`=1.
- rd_data  out  DATA_W  read data; valid in the DONE cycle, held until next completion.
- stall  out  1  CPU must hold the request and freeze the pipeline while high.
- busy  out  1  high in WAIT or DONE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, counter=0, `rd_data`=0, `busy`=0. `stall` is forced 0 while rst=1. The storage array is NOT cleared.
- States:
  - IDLE: if (re|we), capture op, addr[DEPTH_LOG2-1:0] and wrt_data; load counter=LATENCY-1; go to WAIT (or straight to DONE if LATENCY=1).
  - WAIT: decrement counter; at counter==0 go to DONE.
  - DONE: one cycle. A write commits to the array at the edge entering DONE. A read loads `rd_data` from the array at that same edge. Always return to IDLE.
- stall = (IDLE & (re|we)) | WAIT. It is combinational in IDLE so the requesting cycle is stalled; stall=0 in DONE.
- Latency: request first visible in cycle 0 → DONE in cycle LATENCY. CPU advances at the end of the DONE cycle.
- Request seen in the DONE cycle: ignored. It is the request being completed, and the CPU moves on at that edge.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. Throughput is 1 access per LATENCY+1 cycles.
- re & we both high: treated as a write. `rd_data` returns the written value (write-through read).
- Address wrap: upper ADDR_W-DEPTH_LOG2 bits are ignored. Example: 0x1005 aliases 0x0005.
- Inputs changing in WAIT are ignored; only captured values are used.
- Reset mid-operation (WAIT or DONE before its edge): access aborted, write not committed, `rd_data`=0, IDLE next cycle.
- No request (re=we=0): remain IDLE, `rd_data` holds its last value.

Optional Feature:
- Macro: DM_ACCESS_STATS_EN.
- When defined, adds two outputs:
  - rd_cnt out 16: reads completed.
  - wr_cnt out 16: writes completed, including re&we accesses.
- Each counter increments on the DONE cycle, saturates at 0xFFFF and is cleared by rst.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dm_pkg:
  - state enum {IDLE, WAIT, DONE}.
  - default widths (16/16/12) and default LATENCY.
  - op encoding {OP_RD, OP_WR}.
- One sub-module, dm_array: single-port synchronous word array (DEPTH_LOG2, DATA_W) with we, addr, wdata, rdata, and no reset. The FSM, counter and capture registers stay in data_mem_responder.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, re=we=0 → `rd_data`=0, `stall`=0, `busy`=0.
- Write then read, LATENCY=4: we=1 addr=0x0010 data=0xBEEF → `stall` high cycles 0–3, low cycle 4; array[0x10]=0xBEEF. Then re=1 addr=0x0010 → `rd_data`=0xBEEF in cycle 4 of that access.
- Alias and re&we: write 0x1234 to 0x1005 → read 0x0005 returns 0x1234. re=we=1, addr=0x0020, data=0x00A5 → `rd_data`=0x00A5 and array[0x20]=0x00A5.
- Reset mid-write: we=1 addr=0x0030 data=0x5555, rst=1 in cycle 2 → FSM IDLE next cycle, array[0x30] keeps its prior value (0x0000 after preload), `stall` drops.
- LATENCY=1 back-to-back: reads of 0x0001 then 0x0002 held per the stall protocol → each completes in 2 cycles, `stall` pattern 1,0,1,0, correct data for each.
- With DM_ACCESS_STATS_EN: 3 reads + 2 writes + 1 re&we → rd_cnt=3, wr_cnt=3. Preloading wr_cnt at 0xFFFF via force then another write → stays 0xFFFF.
